// File: rtl/reservation_station_pkg.sv
// Shared CPU definitions: internal opcode encoding, default widths and
// the tag helper used by the dispatcher, RS, LSB and ALU.
package cpu_defs;

    localparam int RS_WIDTH_DEF  = 2;
    localparam int ROB_WIDTH_DEF = 3;

    // Internal 7-bit opcodes; numbering is contiguous from OP_LUI.
    typedef enum logic [6:0] {
        OP_LUI  = 7'd1,
        OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XORR,
        OP_SRL, OP_SRA, OP_ORR, OP_ANDR
    } opcode_e;

    // A tag is RoB_WIDTH+1 bits; only the MSB set with zero index means
    // "operand value is final, no dependency".
    function automatic int unsigned non_dep_of(input int unsigned rob_w);
        return 32'd1 << rob_w;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Bus bundle between the dispatcher/CDBs/ALU side and the reservation station.
// Dispatch writes are strobes: a write presented with RS_newEntry_en is taken
// at the next edge; the dispatcher must respect RS_isFull one cycle ahead.
// ALU_en is a one-cycle issue strobe with no back-pressure from the ALU.
interface reservation_station_if #(
    parameter int RoB_WIDTH = 3
);
    logic                 RoB_flush_signal;
    logic                 RS_newEntry_en;
    logic [RoB_WIDTH-1:0] RS_robEntry;
    logic [6:0]           RS_opcode;
    logic [31:0]          RS_Vj;
    logic [31:0]          RS_Vk;
    logic [RoB_WIDTH:0]   RS_Qj;
    logic [RoB_WIDTH:0]   RS_Qk;
    logic [31:0]          RS_imm;
    logic [31:0]          RS_pc;
    logic                 RS_isFull;
    logic                 ALU_cdb_en;
    logic [RoB_WIDTH-1:0] ALU_cdb_robIndex;
    logic [31:0]          ALU_cdb_data;
    logic                 LSB_cdb_en;
    logic [RoB_WIDTH-1:0] LSB_cdb_robIndex;
    logic [31:0]          LSB_cdb_data;
    logic                 ALU_en;
    logic [RoB_WIDTH-1:0] ALU_robEntry;
    logic [6:0]           ALU_opcode;
    logic [31:0]          ALU_Vj;
    logic [31:0]          ALU_Vk;
    logic [31:0]          ALU_imm;
    logic [31:0]          ALU_pc;

    modport master (
        output RoB_flush_signal, RS_newEntry_en, RS_robEntry, RS_opcode,
               RS_Vj, RS_Vk, RS_Qj, RS_Qk, RS_imm, RS_pc,
               ALU_cdb_en, ALU_cdb_robIndex, ALU_cdb_data,
               LSB_cdb_en, LSB_cdb_robIndex, LSB_cdb_data,
        input  RS_isFull, ALU_en, ALU_robEntry, ALU_opcode,
               ALU_Vj, ALU_Vk, ALU_imm, ALU_pc
    );

    modport slave (
        input  RoB_flush_signal, RS_newEntry_en, RS_robEntry, RS_opcode,
               RS_Vj, RS_Vk, RS_Qj, RS_Qk, RS_imm, RS_pc,
               ALU_cdb_en, ALU_cdb_robIndex, ALU_cdb_data,
               LSB_cdb_en, LSB_cdb_robIndex, LSB_cdb_data,
        output RS_isFull, ALU_en, ALU_robEntry, ALU_opcode,
               ALU_Vj, ALU_Vk, ALU_imm, ALU_pc
    );
endinterface

// File: rtl/reservation_station_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_select #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched micro-ops until both operands are
// resolved (directly or from the ALU/LSB result buses) and issues the
// lowest-index ready entry to the ALU, one per cycle.
module reservation_station
    import cpu_defs::*;
#(
    parameter int RS_WIDTH  = RS_WIDTH_DEF,
    parameter int RoB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    reservation_station_if.slave bus
);

    localparam int SIZE  = 1 << RS_WIDTH;
    localparam int TAG_W = RoB_WIDTH + 1;
    localparam int CNT_W = RS_WIDTH + 2;
    localparam logic [TAG_W-1:0] NON_DEP = TAG_W'(non_dep_of(RoB_WIDTH));

    // Entry storage
    logic [SIZE-1:0]      r_valid;
    logic [RoB_WIDTH-1:0] r_rob [SIZE];
    logic [6:0]           r_op  [SIZE];
    logic [31:0]          r_vj  [SIZE];
    logic [31:0]          r_vk  [SIZE];
    logic [TAG_W-1:0]     r_qj  [SIZE];
    logic [TAG_W-1:0]     r_qk  [SIZE];
    logic [31:0]          r_imm [SIZE];
    logic [31:0]          r_pc  [SIZE];

    // Issue registers
    logic                 r_alu_en;
    logic [RoB_WIDTH-1:0] r_alu_rob;
    logic [6:0]           r_alu_op;
    logic [31:0]          r_alu_vj;
    logic [31:0]          r_alu_vk;
    logic [31:0]          r_alu_imm;
    logic [31:0]          r_alu_pc;

    logic [SIZE-1:0]      w_free;
    logic [SIZE-1:0]      w_ready;
    logic                 w_free_found;
    logic [RS_WIDTH-1:0]  w_free_idx;
    logic                 w_ready_found;
    logic [RS_WIDTH-1:0]  w_ready_idx;
    logic [CNT_W-1:0]     w_count;
    logic [CNT_W-1:0]     w_full_sum;
    logic [31:0]          w_new_vj;
    logic [31:0]          w_new_vk;
    logic [TAG_W-1:0]     w_new_qj;
    logic [TAG_W-1:0]     w_new_qk;

    // A tag only names a RoB entry while its MSB is clear.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] q,
                                     input logic en,
                                     input logic [RoB_WIDTH-1:0] idx);
        return en && !q[TAG_W-1] && (q[RoB_WIDTH-1:0] == idx);
    endfunction

    // Same-cycle bypass of incoming operands from the result buses (ALU first).
    always_comb begin
        w_new_vj = bus.RS_Vj;
        w_new_qj = bus.RS_Qj;
        w_new_vk = bus.RS_Vk;
        w_new_qk = bus.RS_Qk;
        if (cdb_hit(bus.RS_Qj, bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
            w_new_vj = bus.ALU_cdb_data;
            w_new_qj = NON_DEP;
        end else if (cdb_hit(bus.RS_Qj, bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
            w_new_vj = bus.LSB_cdb_data;
            w_new_qj = NON_DEP;
        end
        if (cdb_hit(bus.RS_Qk, bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
            w_new_vk = bus.ALU_cdb_data;
            w_new_qk = NON_DEP;
        end else if (cdb_hit(bus.RS_Qk, bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
            w_new_vk = bus.LSB_cdb_data;
            w_new_qk = NON_DEP;
        end
    end

    // Per-slot free/ready flags and the registered occupancy count.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_free[i]  = !r_valid[i];
            w_ready[i] = r_valid[i] && (r_qj[i] == NON_DEP) && (r_qk[i] == NON_DEP);
            w_count    = w_count + CNT_W'(r_valid[i]);
        end
    end

    // Conservative: the same-cycle issue is not credited, which leaves room
    // for the dispatcher's registered write already in flight.
    assign w_full_sum    = w_count + CNT_W'(bus.RS_newEntry_en);
    assign bus.RS_isFull = (w_full_sum >= CNT_W'(SIZE - 1));

    rs_select #(.N(SIZE), .W(RS_WIDTH)) u_free_sel (
        .i_req   (w_free),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_select #(.N(SIZE), .W(RS_WIDTH)) u_ready_sel (
        .i_req   (w_ready),
        .o_found (w_ready_found),
        .o_idx   (w_ready_idx)
    );

    // Entry payload: operand wakeup from the buses and new-entry writes.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !bus.RoB_flush_signal) begin
            for (int i = 0; i < SIZE; i++) begin
                if (r_valid[i]) begin
                    if (cdb_hit(r_qj[i], bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
                        r_vj[i] <= bus.ALU_cdb_data;
                        r_qj[i] <= NON_DEP;
                    end else if (cdb_hit(r_qj[i], bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
                        r_vj[i] <= bus.LSB_cdb_data;
                        r_qj[i] <= NON_DEP;
                    end
                    if (cdb_hit(r_qk[i], bus.ALU_cdb_en, bus.ALU_cdb_robIndex)) begin
                        r_vk[i] <= bus.ALU_cdb_data;
                        r_qk[i] <= NON_DEP;
                    end else if (cdb_hit(r_qk[i], bus.LSB_cdb_en, bus.LSB_cdb_robIndex)) begin
                        r_vk[i] <= bus.LSB_cdb_data;
                        r_qk[i] <= NON_DEP;
                    end
                end
            end
            if (bus.RS_newEntry_en && w_free_found) begin
                r_rob[w_free_idx] <= bus.RS_robEntry;
                r_op[w_free_idx]  <= bus.RS_opcode;
                r_vj[w_free_idx]  <= w_new_vj;
                r_vk[w_free_idx]  <= w_new_vk;
                r_qj[w_free_idx]  <= w_new_qj;
                r_qk[w_free_idx]  <= w_new_qk;
                r_imm[w_free_idx] <= bus.RS_imm;
                r_pc[w_free_idx]  <= bus.RS_pc;
            end
        end
    end

    // Valid bits and issue registers: flush beats write/issue; a slot freed
    // by issue is not the one written this edge (free slot chosen pre-edge).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid   <= '0;
            r_alu_en  <= 1'b0;
            r_alu_rob <= '0;
            r_alu_op  <= '0;
            r_alu_vj  <= '0;
            r_alu_vk  <= '0;
            r_alu_imm <= '0;
            r_alu_pc  <= '0;
        end else if (rdy_in) begin
            if (bus.RoB_flush_signal) begin
                r_valid  <= '0;
                r_alu_en <= 1'b0;
            end else begin
                r_alu_en <= w_ready_found;
                if (w_ready_found) begin
                    r_alu_rob            <= r_rob[w_ready_idx];
                    r_alu_op             <= r_op[w_ready_idx];
                    r_alu_vj             <= r_vj[w_ready_idx];
                    r_alu_vk             <= r_vk[w_ready_idx];
                    r_alu_imm            <= r_imm[w_ready_idx];
                    r_alu_pc             <= r_pc[w_ready_idx];
                    r_valid[w_ready_idx] <= 1'b0;
                end
                if (bus.RS_newEntry_en && w_free_found) begin
                    r_valid[w_free_idx] <= 1'b1;
                end
            end
        end
    end

    // A write with every slot occupied means the dispatcher ignored RS_isFull.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && !bus.RoB_flush_signal && bus.RS_newEntry_en) begin
            assert (w_free_found)
            else $error("reservation_station: write with no free slot");
        end
    end

    assign bus.ALU_en       = r_alu_en;
    assign bus.ALU_robEntry = r_alu_rob;
    assign bus.ALU_opcode   = r_alu_op;
    assign bus.ALU_Vj       = r_alu_vj;
    assign bus.ALU_Vk       = r_alu_vk;
    assign bus.ALU_imm      = r_alu_imm;
    assign bus.ALU_pc       = r_alu_pc;

endmodule
